// File: rtl/frame_sequencer.sv
// Frame sequencer: divides clk to a 512 Hz step tick and issues length/sweep/envelope strobes.
// Optional FS_EXT_TICK_EN: ticks come from falling edges of div_bit instead of the internal prescaler.
module frame_sequencer #(
  parameter int CLK_DIV = 8192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_enable,
  input  logic       div_bit,
  output logic       len_clk,
  output logic       sweep_clk,
  output logic       env_clk,
  output logic [2:0] step,
  output logic       len_next_skips
);

  logic       w_tick;
  logic [2:0] r_step;
  logic       r_len_clk;
  logic       r_sweep_clk;
  logic       r_env_clk;

`ifdef FS_EXT_TICK_EN
  logic r_div_q;

  // History tracks div_bit even while disabled so enabling with div_bit high cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_q <= 1'b0;
    end else begin
      r_div_q <= div_bit;
    end
  end

  assign w_tick = r_div_q & ~div_bit;
`else
  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] r_presc;
  logic             w_unused_div_bit;

  assign w_unused_div_bit = div_bit;
  assign w_tick           = (r_presc == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (!apu_enable || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end
`endif

  // Disable outranks a coincident tick; strobes decode the step being executed, not the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step      <= 3'd0;
      r_len_clk   <= 1'b0;
      r_sweep_clk <= 1'b0;
      r_env_clk   <= 1'b0;
    end else if (!apu_enable) begin
      r_step      <= 3'd0;
      r_len_clk   <= 1'b0;
      r_sweep_clk <= 1'b0;
      r_env_clk   <= 1'b0;
    end else if (w_tick) begin
      r_step      <= r_step + 3'd1;
      r_len_clk   <= ~r_step[0];
      r_sweep_clk <= (r_step[1:0] == 2'b10);
      r_env_clk   <= (r_step == 3'd7);
    end else begin
      r_len_clk   <= 1'b0;
      r_sweep_clk <= 1'b0;
      r_env_clk   <= 1'b0;
    end
  end

  assign len_clk        = r_len_clk;
  assign sweep_clk      = r_sweep_clk;
  assign env_clk        = r_env_clk;
  assign step           = r_step;
  assign len_next_skips = r_step[0];

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Generates the timing strobes that clock the per-channel sound units: length counters (256 Hz), frequency sweep (128 Hz) and volume envelope (64 Hz).
- A prescaler divides the system clock down to a 512 Hz step tick. An 8-step counter then decides which strobes fire on each tick.
- Sits between the APU power control (the master enable register bit) and every channel instance. Its len_clk drives the clk input of each length counter.

Parameters:
- CLK_DIV, 8192, system clocks per sequencer step (4.194304 MHz / 512 Hz). Must be >= 2.
- CNT_W, $clog2(CLK_DIV), prescaler width. Derived; do not override.

Ports:
- clk  input  1  system clock, 4.194304 MHz nominal.
- rst_n  input  1  asynchronous reset, active-low.
- apu_enable  input  1  master sound enable. Low holds the sequencer idle and reset to step 0.
- div_bit  input  1  external divider tap. Used only when FS_EXT_TICK_EN is defined; ignored otherwise.
- len_clk  output  1  one-cycle pulse that clocks the length counters.
- sweep_clk  output  1  one-cycle pulse that clocks the sweep unit.
- env_clk  output  1  one-cycle pulse that clocks the envelope units.
- step  output  3  index of the next step to execute.
- len_next_skips  output  1  high when the next step does not clock the length counters; used by the channel trigger logic.

Behaviour:
- Reset (rst_n low, asynchronous):
  - prescaler = 0, step = 0.
  - len_clk, sweep_clk, env_clk = 0.
  - div_bit history register = 0.
- Disabled (apu_enable sampled low at a clk edge):
  - prescaler <= 0, step <= 0, all strobes <= 0.
  - No tick is generated. Disable takes priority over a coincident tick.
- Tick generation (internal mode):
  - While enabled, the prescaler increments every clk edge.
  - When prescaler == CLK_DIV-1, the prescaler wraps to 0 on that edge and a tick occurs.
  - The first tick after enable therefore occurs on the CLK_DIV-th enabled edge.
- On a tick, at the same edge:
  - Strobes are registered from the current step s.
  - Then step <= s+1 mod 8. Step 7 wraps to 0.
- Strobe decode for executed step s:
  - len_clk = 1 for s in {0, 2, 4, 6}.
  - sweep_clk = 1 for s in {2, 6}.
  - env_clk = 1 for s == 7.
  - Steps 1, 3 and 5 produce no strobe.
- Strobe timing:
  - Strobes are high for exactly one clk cycle, the cycle following the tick edge.
  - They are cleared on the next edge unless another tick occurs. In internal mode this requires CLK_DIV >= 2, so strobes never merge.
- len_next_skips = step[0]. It is registered through step, so there is no combinational path from inputs.
- Re-enable: after apu_enable goes low then high, the first executed step is 0. The first len_clk therefore follows CLK_DIV enabled cycles.
- Outputs are glitch-free registers; step is observable directly.

Optional Feature:
- Macro: FS_EXT_TICK_EN.
- Defined:
  - The prescaler is removed. Ticks come from a falling edge of div_bit: a registered copy of div_bit was 1 and the current div_bit is 0, while enabled.
  - The history register updates every edge regardless of apu_enable. This prevents a spurious tick at enable.
  - All decode and disable rules are unchanged.
  - Consecutive falling edges must be >= 2 clk apart.
- Not defined:
  - The internal prescaler as described above. div_bit is unused.

Test Plan:
1. Set CLK_DIV=4. Release reset with apu_enable=1 held. Expect the first len_clk pulse in the cycle after the 4th edge. Over 32 cycles, expect 8 ticks: len_clk at steps 0, 2, 4, 6; sweep_clk at steps 2 and 6; env_clk at step 7 only; and step returning to 0.
2. Set CLK_DIV=4. Check each strobe pulse is exactly 1 cycle wide. Check len_next_skips equals 0, 1, 0, 1, ... as step advances 0..7.
3. Set CLK_DIV=4. Drop apu_enable on the exact tick edge after step 3. Expect no strobe, step=0 and prescaler=0. Re-enable and expect the next tick to execute step 0, giving len_clk=1.
4. Assert rst_n low asynchronously mid-prescale, with step=5 and a strobe high. Expect all outputs 0 and step=0 immediately, without waiting for a clk edge.
5. Define FS_EXT_TICK_EN. Hold div_bit=1 and raise apu_enable: expect no tick. Drive 8 falling edges of div_bit: expect the same strobe sequence as test 1, one step per falling edge. Rising edges must not advance step.
